// File: rtl/uart_rx_ctrl.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with RX FIFO,
// sticky error flags, programmable bit divisor and an APB register interface.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned DIVISOR_RESET = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [3:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif

  logic          r_rx_meta, r_rx_sync, r_rx_d;
  state_t        r_state;
  logic [15:0]   r_cyc, r_bit, r_div, r_div_act;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_perr, r_ferr, r_ovr, r_irq;

  logic w_fall, w_tick, w_push, w_ferr_set, w_perr_set;
  logic w_access, w_rd_data, w_wr_stat, w_wr_div, w_bad_addr;
  logic w_full, w_empty, w_pop, w_wr_en, w_ovr_set;
  logic [6:0]  w_count7;
  logic [15:0] w_div_wr;
  logic        w_unused_pwdata;

  assign w_fall = r_rx_d & ~r_rx_sync;
  assign w_tick = (r_cyc <= 16'd1);

  assign w_push     = (r_state == S_STOP) & w_tick & r_rx_sync;
  assign w_ferr_set = (r_state == S_STOP) & w_tick & ~r_rx_sync;
`ifdef UART_RX_PARITY_EN
  assign w_perr_set = (r_state == S_PARITY) & w_tick & (r_rx_sync != ^r_shift);
`else
  assign w_perr_set = 1'b0;
`endif

  assign w_access   = PSEL & PENABLE;
  assign w_rd_data  = w_access & ~PWRITE & (PADDR == 4'h0);
  assign w_wr_stat  = w_access & PWRITE & (PADDR == 4'h4);
  assign w_wr_div   = w_access & PWRITE & (PADDR == 4'h8);
  assign w_bad_addr = (PADDR != 4'h0) & (PADDR != 4'h4) & (PADDR != 4'h8);
  assign w_div_wr   = (PWDATA[15:0] < 16'd2) ? 16'd2 : PWDATA[15:0];
  assign w_unused_pwdata = &{1'b0, PWDATA[31:16]};

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = w_rd_data & ~w_empty;
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;
  assign w_count7  = 7'(r_count);

  assign PREADY = 1'b1;
  assign irq    = r_irq;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_d    <= r_rx_sync;
    end
  end

  // Receiver FSM; r_cyc counts down to the next sample point
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_div_act <= 16'(DIVISOR_RESET);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state   <= S_START;
            r_cyc     <= r_div >> 1;
            r_div_act <= r_div;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_cyc   <= r_div_act;
            r_bit   <= '0;
            r_state <= r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            r_cyc <= r_cyc - 16'd1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_cyc   <= r_div_act;
            r_bit   <= r_bit + 16'd1;
            if (r_bit == 16'd7) r_state <= S_AFTER_DATA;
          end else begin
            r_cyc <= r_cyc - 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_cyc   <= r_div_act;
            r_state <= S_STOP;
          end else begin
            r_cyc <= r_cyc - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) r_state <= r_rx_sync ? S_IDLE : S_BREAK;
          else        r_cyc   <= r_cyc - 16'd1;
        end
        S_BREAK: begin
          if (r_rx_sync) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr] <= r_shift;
  end

  // FIFO pointers/count, sticky flags (set beats W1C), divisor and irq
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_div   <= 16'(DIVISOR_RESET);
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + AW'(1);
      if (w_pop)   r_rptr <= r_rptr + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_perr <= w_perr_set | (r_perr & ~(w_wr_stat & PWDATA[8]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_wr_stat & PWDATA[9]));
      r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_wr_stat & PWDATA[10]));
      if (w_wr_div) r_div <= w_div_wr;
      r_irq <= (r_count != '0) | r_perr | r_ferr | r_ovr;
    end
  end

  // Combinational APB read data and error response
  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (w_access) begin
      PSLVERR = w_bad_addr;
      if (!PWRITE) begin
        case (PADDR)
          4'h0:    PRDATA = w_empty ? 32'h0000_0100 : {24'd0, r_mem[r_rptr]};
          4'h4:    PRDATA = {21'd0, r_ovr, r_ferr, r_perr, 1'b0, w_count7};
          4'h8:    PRDATA = {16'd0, r_div};
          default: PRDATA = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: APB reads push expected values, a monitor
// compares them in the access phase. Works with or without UART_RX_PARITY_EN.
module tb_uart_rx_ctrl;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, rx;
  logic [3:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, irq;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(8), .DIVISOR_RESET(3)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_data [$];
  logic        q_err  [$];
  bit          q_cmp  [$];
  string       q_name [$];

  string       m_name;
  logic [31:0] m_data;
  logic        m_err;
  bit          m_cmp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every APB access phase consumes one scoreboard entry
  always @(negedge clk) begin
    if (PSEL && PENABLE) begin
      if (q_name.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL apb_unexpected: access to 0x%0h with empty scoreboard", PADDR);
      end else begin
        m_name = q_name.pop_front();
        m_data = q_data.pop_front();
        m_err  = q_err.pop_front();
        m_cmp  = q_cmp.pop_front();
        if (m_cmp) check({m_name, "_data"}, PRDATA, m_data);
        check({m_name, "_err"}, {31'd0, PSLVERR}, {31'd0, m_err});
        check({m_name, "_ready"}, {31'd0, PREADY}, 32'd1);
      end
    end
  end

  task automatic apb_read(input logic [3:0] a, input logic [31:0] exp, input logic exp_err,
                          input string name);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    q_data.push_back(exp); q_err.push_back(exp_err); q_cmp.push_back(1'b1); q_name.push_back(name);
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    apb_read(a, exp, 1'b0, name);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic exp_err,
                    input string name);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    q_data.push_back(32'd0); q_err.push_back(exp_err); q_cmp.push_back(1'b0); q_name.push_back(name);
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic bit_time(input logic v, input int div);
    rx = v;
    repeat (div) @(posedge clk);
    #1;
  endtask

  // One frame: bad_par inverts the even-parity bit, hold_low extends a low stop bit
  task automatic send_frame(input logic [7:0] b, input int div, input logic bad_par,
                            input logic stop, input int hold_low);
    bit_time(1'b0, div);
    for (int i = 0; i < 8; i++) bit_time(b[i], div);
    if (PAR_EN) bit_time((^b) ^ bad_par, div);
    bit_time(stop, div);
    if (hold_low > 0) begin
      rx = 1'b0;
      repeat (hold_low) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (2 * div + 6) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int div);
    send_frame(b, div, 1'b0, 1'b1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0; PWDATA = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    rd(4'h4, 32'h000, "rst_status");
    rd(4'h0, 32'h100, "rst_data");
    rd(4'h8, 32'd3,   "rst_div");
    apb_read(4'hC, 32'd0, 1'b1, "bad_rd_c");
    wr(4'hC, 32'h0000_FFFF, 1'b1, "bad_wr_c");
    rd(4'h8, 32'd3, "div_after_bad_wr");
    apb_read(4'h2, 32'd0, 1'b1, "bad_rd_2");

    // Clean frame, then pop to empty
    send(8'hA5, 3);
    rd(4'h4, 32'h001, "a5_status");
    check("a5_irq", {31'd0, irq}, 32'd1);
    rd(4'h0, 32'h0A5, "a5_data");
    rd(4'h0, 32'h100, "a5_empty");

    // Wrong parity bit (only meaningful for 8E1); byte still stored
    send_frame(8'h3C, 3, 1'b1, 1'b1, 0);
    rd(4'h4, PAR_EN ? 32'h101 : 32'h001, "3c_status");
    rd(4'h0, 32'h03C, "3c_data");
    wr(4'h4, 32'h100, 1'b0, "clr_perr");
    repeat (2) @(posedge clk);
    #1;
    check("clr_perr_irq", {31'd0, irq}, 32'd0);
    rd(4'h4, 32'h000, "status_after_clr_perr");

    send(8'hC3, 3);
    rd(4'h0, 32'h0C3, "c3_data");

    // Framing error with a long break, then recovery
    send_frame(8'h55, 3, 1'b0, 1'b0, 40);
    rd(4'h4, 32'h200, "ferr_status");
    check("ferr_irq", {31'd0, irq}, 32'd1);
    send(8'h12, 3);
    rd(4'h4, 32'h201, "after_break_status");
    rd(4'h0, 32'h012, "after_break_data");
    wr(4'h4, 32'h200, 1'b0, "clr_ferr");
    rd(4'h4, 32'h000, "status_after_clr_ferr");

    // Overrun: nine bytes into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) send(8'(i), 3);
    rd(4'h4, 32'h408, "ovr_status");
    for (int i = 1; i <= 8; i++) rd(4'h0, 32'(i), "ovr_data");
    rd(4'h0, 32'h100, "ovr_empty");
    wr(4'h4, 32'h400, 1'b0, "clr_ovr");
    rd(4'h4, 32'h000, "status_after_clr_ovr");

    // Divisor 16: a short low glitch is rejected, a real frame is received
    wr(4'h8, 32'd16, 1'b0, "div16_wr");
    rd(4'h8, 32'd16, "div16_rd");
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rd(4'h4, 32'h000, "glitch_status");
    send(8'h5A, 16);
    rd(4'h0, 32'h05A, "div16_data");

    // Divisor clamps to 2
    wr(4'h8, 32'd0, 1'b0, "div0_wr");
    rd(4'h8, 32'd2, "div0_rd");
    wr(4'h8, 32'd1, 1'b0, "div1_wr");
    rd(4'h8, 32'd2, "div1_rd");
    send(8'h96, 2);
    rd(4'h4, 32'h001, "div2_status");

    // Reset in the middle of a frame with a byte left in the FIFO
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    rx = 1'b0;
    repeat (12) @(posedge clk);
    #1 reset = 1'b1; rx = 1'b1;
    @(posedge clk); #1;
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_prdata", PRDATA, 32'd0);
    check("midrst_pslverr", {31'd0, PSLVERR}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    rd(4'h4, 32'h000, "midrst_status");
    rd(4'h0, 32'h100, "midrst_data");
    rd(4'h8, 32'd3,   "midrst_div");
    send(8'h33, 3);
    rd(4'h0, 32'h033, "post_rst_data");

    repeat (4) @(posedge clk);
    if (q_name.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 required", q_name.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
